// File: rtl/rf_write_arbiter_pkg.sv
// Shared defaults and write-back source encoding for the register-file write arbiter.
package mips_rf_pkg;

    localparam int RF_N = 8;
    localparam int RF_M = 4;

    typedef enum logic [1:0] {
        WB_NONE      = 2'd0,
        WB_ALU       = 2'd1,
        WB_LD_DIRECT = 2'd2,
        WB_LD_Q      = 2'd3
    } wb_src_e;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Write-back bus: ALU and load producers in, regfile write port and decode bypass out.
interface rf_wb_if
    import mips_rf_pkg::*;
#(
    parameter int N  = RF_N,
    parameter int AW = $clog2(RF_M),
    parameter int PW = 3
);
    logic          alu_valid;
    logic [AW-1:0] alu_waddr;
    logic [N-1:0]  alu_wdata;
    logic          alu_stall;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_waddr;
    logic [N-1:0]  ld_wdata;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic [AW-1:0] byp_raddr1;
    logic [AW-1:0] byp_raddr2;
    logic          byp_hit1;
    logic          byp_hit2;
    logic [N-1:0]  byp_data1;
    logic [N-1:0]  byp_data2;
    logic [PW-1:0] pending;

    modport slave (
        input  alu_valid, alu_waddr, alu_wdata, ld_valid, ld_waddr, ld_wdata,
               byp_raddr1, byp_raddr2,
        output alu_stall, ld_ready, rf_we, rf_waddr, rf_wdata,
               byp_hit1, byp_hit2, byp_data1, byp_data2, pending
    );

    modport master (
        output alu_valid, alu_waddr, alu_wdata, ld_valid, ld_waddr, ld_wdata,
               byp_raddr1, byp_raddr2,
        input  alu_stall, ld_ready, rf_we, rf_waddr, rf_wdata,
               byp_hit1, byp_hit2, byp_data1, byp_data2, pending
    );
endinterface

// File: rtl/rf_write_arbiter_wb_kill_fifo.sv
// In-order load queue whose entries can be invalidated by address, with per-entry
// live address-match outputs for the bypass network.
module wb_kill_fifo #(
    parameter int N     = 8,
    parameter int AW    = 2,
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic                      i_push_live,
    input  logic [AW-1:0]             i_push_addr,
    input  logic [N-1:0]              i_push_data,
    input  logic                      i_pop,
    input  logic                      i_kill0_en,
    input  logic [AW-1:0]             i_kill0_addr,
    input  logic                      i_kill1_en,
    input  logic [AW-1:0]             i_kill1_addr,
    input  logic [AW-1:0]             i_byp_addr1,
    input  logic [AW-1:0]             i_byp_addr2,
    output logic                      o_empty,
    output logic                      o_full,
    output logic                      o_head_live,
    output logic [AW-1:0]             o_head_addr,
    output logic [N-1:0]              o_head_data,
    output logic [DEPTH-1:0]          o_match1,
    output logic [DEPTH-1:0]          o_match2,
    output logic [DEPTH-1:0][N-1:0]   o_data,
    output logic [PW-1:0]             o_live_cnt_nxt
);
    localparam int PTRW = $clog2(DEPTH) + 1;
    localparam int IW   = PTRW - 1;

    logic [PTRW-1:0]           r_wptr;
    logic [PTRW-1:0]           r_rptr;
    logic [DEPTH-1:0]          r_live;
    logic [DEPTH-1:0][AW-1:0]  r_addr;
    logic [DEPTH-1:0][N-1:0]   r_data;
    logic [DEPTH-1:0]          w_live_nxt;
    logic [IW-1:0]             w_widx;
    logic [IW-1:0]             w_ridx;

    assign w_widx      = r_wptr[IW-1:0];
    assign w_ridx      = r_rptr[IW-1:0];
    assign o_empty     = (r_wptr == r_rptr);
    assign o_full      = (r_wptr[IW] != r_rptr[IW]) && (w_widx == w_ridx);
    assign o_head_live = r_live[w_ridx] && !o_empty;
    assign o_head_addr = r_addr[w_ridx];
    assign o_head_data = r_data[w_ridx];
    assign o_data      = r_data;

    // Next liveness: kills and pop apply to resident entries, then the new slot is filled.
    always_comb begin
        w_live_nxt     = r_live;
        o_live_cnt_nxt = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if ((i_kill0_en && (r_addr[i] == i_kill0_addr)) ||
                (i_kill1_en && (r_addr[i] == i_kill1_addr)) ||
                (i_pop && (w_ridx == IW'(i)))) begin
                w_live_nxt[i] = 1'b0;
            end else begin
                w_live_nxt[i] = r_live[i];
            end
            if (i_push && (w_widx == IW'(i))) begin
                w_live_nxt[i] = i_push_live;
            end else begin
                w_live_nxt[i] = w_live_nxt[i];
            end
            o_live_cnt_nxt = o_live_cnt_nxt + PW'(w_live_nxt[i]);
        end
    end

    // Bypass match only counts entries that will still be written.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_match1[i] = r_live[i] && (r_addr[i] == i_byp_addr1);
            o_match2[i] = r_live[i] && (r_addr[i] == i_byp_addr2);
        end
    end

    // Queue storage and pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= {PTRW{1'b0}};
            r_rptr <= {PTRW{1'b0}};
            r_live <= {DEPTH{1'b0}};
            r_addr <= {(DEPTH*AW){1'b0}};
            r_data <= {(DEPTH*N){1'b0}};
        end else begin
            r_live <= w_live_nxt;
            if (i_push) begin
                r_addr[w_widx] <= i_push_addr;
                r_data[w_widx] <= i_push_data;
                r_wptr         <= r_wptr + PTRW'(1);
            end
            if (i_pop) begin
                r_rptr <= r_rptr + PTRW'(1);
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Regfile write-port arbiter: ALU first, queued loads in order, direct load when idle,
// WAW kill of stale queued loads and a bypass view of every pending write.
module rf_write_arbiter
    import mips_rf_pkg::*;
#(
    parameter int N        = RF_N,
    parameter int M        = RF_M,
    parameter int DEPTH    = 4,
    parameter int ZERO_REG = 1
) (
    input  logic    clk,
    input  logic    rst,
    rf_wb_if.slave  wb
);
    localparam int AW = $clog2(M);
    localparam int PW = $clog2(DEPTH + 1);

    wb_src_e                   w_src;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_push_live;
    logic                      w_empty;
    logic                      w_full;
    logic                      w_head_live;
    logic [AW-1:0]             w_head_addr;
    logic [N-1:0]              w_head_data;
    logic [DEPTH-1:0]          w_match1;
    logic [DEPTH-1:0]          w_match2;
    logic [DEPTH-1:0][N-1:0]   w_ent_data;
    logic [PW-1:0]             w_live_cnt_nxt;
    logic [AW-1:0]             w_sel_addr;
    logic [N-1:0]              w_sel_data;
    logic                      w_we;
    logic                      w_ld_zero;
    logic                      w_rf_hit1;
    logic                      w_rf_hit2;
    logic [N-1:0]              w_q_data1;
    logic [N-1:0]              w_q_data2;
    logic [PW-1:0]             r_pending;

    // Source selection; a non-empty queue always pops when the ALU is idle.
    always_comb begin
        w_pop = 1'b0;
        if (wb.alu_valid) begin
            w_src = WB_ALU;
        end else if (!w_empty) begin
            w_pop = 1'b1;
            w_src = w_head_live ? WB_LD_Q : WB_NONE;
        end else if (wb.ld_valid) begin
            w_src = WB_LD_DIRECT;
        end else begin
            w_src = WB_NONE;
        end
    end

    // Write-port data mux.
    always_comb begin
        case (w_src)
            WB_ALU: begin
                w_sel_addr = wb.alu_waddr;
                w_sel_data = wb.alu_wdata;
            end
            WB_LD_Q: begin
                w_sel_addr = w_head_addr;
                w_sel_data = w_head_data;
            end
            WB_LD_DIRECT: begin
                w_sel_addr = wb.ld_waddr;
                w_sel_data = wb.ld_wdata;
            end
            default: begin
                w_sel_addr = {AW{1'b0}};
                w_sel_data = {N{1'b0}};
            end
        endcase
    end

    assign w_we = (w_src != WB_NONE) &&
                  !((ZERO_REG != 0) && (w_sel_addr == {AW{1'b0}}));
    assign wb.rf_we    = w_we;
    assign wb.rf_waddr = w_we ? w_sel_addr : {AW{1'b0}};
    assign wb.rf_wdata = w_we ? w_sel_data : {N{1'b0}};

    // No pass-through when full, even if the head pops this cycle.
    assign wb.ld_ready  = !w_full;
    assign wb.alu_stall = w_full;
    assign w_ld_zero    = (ZERO_REG != 0) && (wb.ld_waddr == {AW{1'b0}});
    assign w_push       = wb.ld_valid && !w_full && (w_src != WB_LD_DIRECT) && !w_ld_zero;
    // Same-cycle ALU write to the same register is newer than the load.
    assign w_push_live  = !(wb.alu_valid && (wb.alu_waddr == wb.ld_waddr));

    wb_kill_fifo #(
        .N     (N),
        .AW    (AW),
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_push         (w_push),
        .i_push_live    (w_push_live),
        .i_push_addr    (wb.ld_waddr),
        .i_push_data    (wb.ld_wdata),
        .i_pop          (w_pop),
        .i_kill0_en     (wb.alu_valid),
        .i_kill0_addr   (wb.alu_waddr),
        .i_kill1_en     (w_push),
        .i_kill1_addr   (wb.ld_waddr),
        .i_byp_addr1    (wb.byp_raddr1),
        .i_byp_addr2    (wb.byp_raddr2),
        .o_empty        (w_empty),
        .o_full         (w_full),
        .o_head_live    (w_head_live),
        .o_head_addr    (w_head_addr),
        .o_head_data    (w_head_data),
        .o_match1       (w_match1),
        .o_match2       (w_match2),
        .o_data         (w_ent_data),
        .o_live_cnt_nxt (w_live_cnt_nxt)
    );

    // Queue-side bypass data; at most one live entry per address, so OR-merge is exact.
    always_comb begin
        w_q_data1 = {N{1'b0}};
        w_q_data2 = {N{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (w_match1[i]) begin
                w_q_data1 = w_q_data1 | w_ent_data[i];
            end else begin
                w_q_data1 = w_q_data1;
            end
            if (w_match2[i]) begin
                w_q_data2 = w_q_data2 | w_ent_data[i];
            end else begin
                w_q_data2 = w_q_data2;
            end
        end
    end

    // The current write wins over a queued entry that it is about to kill.
    assign w_rf_hit1    = w_we && (w_sel_addr == wb.byp_raddr1);
    assign w_rf_hit2    = w_we && (w_sel_addr == wb.byp_raddr2);
    assign wb.byp_hit1  = w_rf_hit1 || (|w_match1);
    assign wb.byp_hit2  = w_rf_hit2 || (|w_match2);
    assign wb.byp_data1 = w_rf_hit1 ? w_sel_data : w_q_data1;
    assign wb.byp_data2 = w_rf_hit2 ? w_sel_data : w_q_data2;

    // Live-entry occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending <= {PW{1'b0}};
        end else begin
            r_pending <= w_live_cnt_nxt;
        end
    end

    assign wb.pending = r_pending;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: expected regfile writes go into a scoreboard
// queue, a negedge monitor pops and compares every rf_we cycle.
module tb_rf_write_arbiter;
    localparam int N     = 8;
    localparam int M     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int PW    = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rf_wb_if #(.N(N), .AW(AW), .PW(PW)) ifc ();

    rf_write_arbiter #(.N(N), .M(M), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (ifc)
    );

    int checks = 0;
    int errors = 0;
    logic [AW+N-1:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [N-1:0] ad,
                         input logic lv, input logic [AW-1:0] la, input logic [N-1:0] ldd);
        ifc.alu_valid = av;
        ifc.alu_waddr = aa;
        ifc.alu_wdata = ad;
        ifc.ld_valid  = lv;
        ifc.ld_waddr  = la;
        ifc.ld_wdata  = ldd;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [N-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (ifc.rf_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write unexpected got addr %0d data 0x%0h expected no write",
                         ifc.rf_waddr, ifc.rf_wdata);
            end else begin
                logic [AW+N-1:0] e;
                e = exp_q.pop_front();
                if ({ifc.rf_waddr, ifc.rf_wdata} !== e) begin
                    errors++;
                    $display("FAIL rf_write got addr %0d data 0x%0h expected addr %0d data 0x%0h",
                             ifc.rf_waddr, ifc.rf_wdata, e[AW+N-1:N], e[N-1:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        idle();
        ifc.byp_raddr1 = 2'd1;
        ifc.byp_raddr2 = 2'd2;
        @(posedge clk);
        @(negedge clk);
        chk("reset_rf_we",     32'(ifc.rf_we),     32'd0);
        chk("reset_rf_waddr",  32'(ifc.rf_waddr),  32'd0);
        chk("reset_rf_wdata",  32'(ifc.rf_wdata),  32'd0);
        chk("reset_alu_stall", 32'(ifc.alu_stall), 32'd0);
        chk("reset_ld_ready",  32'(ifc.ld_ready),  32'd1);
        chk("reset_byp_hit1",  32'(ifc.byp_hit1),  32'd0);
        chk("reset_byp_hit2",  32'(ifc.byp_hit2),  32'd0);
        chk("reset_pending",   32'(ifc.pending),   32'd0);
        step();
        rst = 1'b1;
        step();

        // Priority: ALU first, load queued behind it.
        drive(1'b1, 2'd1, 8'h11, 1'b1, 2'd2, 8'h22);
        expect_wr(2'd1, 8'h11);
        @(negedge clk);
        chk("prio_ld_ready", 32'(ifc.ld_ready), 32'd1);
        step();
        idle();
        expect_wr(2'd2, 8'h22);
        @(negedge clk);
        chk("prio_pending1", 32'(ifc.pending), 32'd1);
        chk("prio_byp_hit2", 32'(ifc.byp_hit2), 32'd1);
        chk("prio_byp_data2", 32'(ifc.byp_data2), 32'h22);
        step();
        @(negedge clk);
        chk("prio_pending0", 32'(ifc.pending), 32'd0);
        step();

        // WAW kill: queued r3=AA overtaken by ALU r3=55.
        drive(1'b1, 2'd1, 8'h01, 1'b1, 2'd3, 8'hAA);
        expect_wr(2'd1, 8'h01);
        step();
        drive(1'b1, 2'd3, 8'h55, 1'b0, 2'd0, 8'h00);
        expect_wr(2'd3, 8'h55);
        ifc.byp_raddr1 = 2'd3;
        @(negedge clk);
        chk("waw_pending1", 32'(ifc.pending), 32'd1);
        chk("waw_byp_hit1", 32'(ifc.byp_hit1), 32'd1);
        chk("waw_byp_data1", 32'(ifc.byp_data1), 32'h55);
        step();
        idle();
        @(negedge clk);
        chk("waw_pending0", 32'(ifc.pending), 32'd0);
        chk("waw_byp_hit1_after", 32'(ifc.byp_hit1), 32'd0);
        step();
        step();

        // Direct path and zero register.
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 8'h7E);
        expect_wr(2'd2, 8'h7E);
        @(negedge clk);
        chk("direct_ld_ready", 32'(ifc.ld_ready), 32'd1);
        step();
        drive(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'h09);
        @(negedge clk);
        chk("direct_pending", 32'(ifc.pending), 32'd0);
        chk("zero_ld_ready", 32'(ifc.ld_ready), 32'd1);
        step();
        idle();
        @(negedge clk);
        chk("zero_pending", 32'(ifc.pending), 32'd0);
        step();

        // Bypass from the younger of two same-address loads.
        drive(1'b1, 2'd2, 8'h33, 1'b1, 2'd1, 8'h10);
        expect_wr(2'd2, 8'h33);
        step();
        drive(1'b1, 2'd2, 8'h34, 1'b1, 2'd1, 8'h20);
        expect_wr(2'd2, 8'h34);
        step();
        idle();
        ifc.byp_raddr2 = 2'd1;
        @(negedge clk);
        chk("byp_pending1", 32'(ifc.pending), 32'd1);
        chk("byp_hit2_q", 32'(ifc.byp_hit2), 32'd1);
        chk("byp_data2_q", 32'(ifc.byp_data2), 32'h20);
        step();
        expect_wr(2'd1, 8'h20);
        @(negedge clk);
        chk("byp_hit2_drain", 32'(ifc.byp_hit2), 32'd1);
        chk("byp_data2_drain", 32'(ifc.byp_data2), 32'h20);
        step();
        @(negedge clk);
        chk("byp_pending0", 32'(ifc.pending), 32'd0);
        chk("byp_hit2_gone", 32'(ifc.byp_hit2), 32'd0);
        step();

        // Fill: ALU busy on r0 for six cycles, four loads r1,r2,r3,r1.
        ifc.byp_raddr1 = 2'd1;
        for (int c = 0; c < 6; c++) begin
            logic [AW-1:0] la;
            logic [N-1:0]  ldd;
            la  = (c == 3) ? 2'd1 : AW'(c + 1);
            ldd = 8'hA1 + N'(c);
            drive(1'b1, 2'd0, 8'hE0 + N'(c), (c < 4), la, ldd);
            if (c > 0 && c < 4) expect_wr(la, ldd);
            @(negedge clk);
            if (c < 4) begin
                chk("fill_ld_ready", 32'(ifc.ld_ready), 32'd1);
            end else begin
                chk("fill_ld_ready_full", 32'(ifc.ld_ready), 32'd0);
                chk("fill_alu_stall", 32'(ifc.alu_stall), 32'd1);
                chk("fill_pending", 32'(ifc.pending), 32'd3);
                chk("fill_byp_data1", 32'(ifc.byp_data1), 32'hA4);
            end
            step();
        end
        idle();
        for (int c = 0; c < 5; c++) step();
        @(negedge clk);
        chk("fill_drained_pending", 32'(ifc.pending), 32'd0);
        chk("fill_drained_stall", 32'(ifc.alu_stall), 32'd0);
        step();

        // Reset with three loads queued.
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 2'd0, 8'hF0, 1'b1, AW'(c + 1), 8'hC1 + N'(c));
            step();
        end
        @(negedge clk);
        chk("mid_pending3", 32'(ifc.pending), 32'd3);
        step();
        idle();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_rf_we", 32'(ifc.rf_we), 32'd0);
        chk("mid_rst_ld_ready", 32'(ifc.ld_ready), 32'd1);
        chk("mid_rst_pending", 32'(ifc.pending), 32'd0);
        chk("mid_rst_byp_hit1", 32'(ifc.byp_hit1), 32'd0);
        step();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
